// File: rtl/decoder3x8_pulse_if.sv
// Handshake/bus bundle for decoder3x8_pulse: code/valid in, ready/data/busy out.
// With DECODER3X8_PARITY_EN defined, also carries the parity input and err flag.
`timescale 1ns/1ps
interface decoder3x8_pulse_if;
  logic [2:0] code;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       busy;
`ifdef DECODER3X8_PARITY_EN
  logic       parity;
  logic       err;

  modport master (output code, valid, parity, input ready, data, busy, err);
  modport slave  (input code, valid, parity, output ready, data, busy, err);
`else
  modport master (output code, valid, input ready, data, busy);
  modport slave  (input code, valid, output ready, data, busy);
`endif
endinterface

// File: rtl/decoder3x8_pulse.sv
// Registered 3-to-8 one-hot decoder: accepts a code, drives a timed one-hot pulse,
// then a quiet gap. Optional parity check on the code under DECODER3X8_PARITY_EN.
`timescale 1ns/1ps
module decoder3x8_pulse #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned CNT_W        = 8
) (
  input logic               clk,
  input logic               rst,
  decoder3x8_pulse_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP
  } state_e;

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYCLES != 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             parity_ok;

`ifdef DECODER3X8_PARITY_EN
  logic err_q, err_d;
  assign parity_ok = (bus.parity == ^bus.code);
  assign bus.err   = err_q;
`else
  assign parity_ok = 1'b1;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset here is synchronous and sampled on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef DECODER3X8_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef DECODER3X8_PARITY_EN
      err_q   <= err_d;
`endif
    end
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef DECODER3X8_PARITY_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.valid) begin
          if (parity_ok) begin
            state_d = ST_DRIVE;
            data_d  = 8'd1 << bus.code;
            cnt_d   = PULSE_LOAD;
          end else begin
`ifdef DECODER3X8_PARITY_EN
            err_d = 1'b1;
`endif
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          data_d = '0;
          if (GAP_CYCLES != 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        data_d  = '0;
      end
    endcase
  end

  // ready comes from registered state only; nothing combinational from valid.
  assign bus.ready = (state_q == ST_IDLE);
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.data  = data_q;

endmodule

// File: tb/tb_decoder3x8_pulse.sv
// Self-checking bench for decoder3x8_pulse: two instances (PULSE=4/GAP=1 and
// PULSE=1/GAP=0) checked every cycle against a timeline model of accepted codes.
`timescale 1ns/1ps
module tb_decoder3x8_pulse;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       valid  = 1'b0;
  logic [2:0] code   = 3'd0;
  logic       parity = 1'b0;

  always #5 clk = ~clk;

  decoder3x8_pulse_if a_if ();
  decoder3x8_pulse_if b_if ();

  assign a_if.code  = code;
  assign a_if.valid = valid;
  assign b_if.code  = code;
  assign b_if.valid = valid;
`ifdef DECODER3X8_PARITY_EN
  assign a_if.parity = parity;
  assign b_if.parity = parity;
`endif

  decoder3x8_pulse #(.PULSE_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  decoder3x8_pulse #(.PULSE_CYCLES(1), .GAP_CYCLES(0), .CNT_W(4)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remember the edge number of the last accepted code per instance;
  // outputs follow from the distance between the current edge and that one.
  function automatic longint pulse_of(int k);
    return (k == 0) ? 4 : 1;
  endfunction
  function automatic longint gap_of(int k);
    return (k == 0) ? 1 : 0;
  endfunction

  longint     edge_n = 0;
  bit         known  = 1'b0;
  bit         acc_v [2];
  longint     acc_e [2];
  logic [2:0] acc_c [2];
  bit         err_x [2];
  int         accepts [2];

  function automatic bit m_ready(int k, longint e);
    return !acc_v[k] || (e - acc_e[k] >= pulse_of(k) + gap_of(k));
  endfunction

  function automatic logic [7:0] m_data(int k, longint e);
    if (acc_v[k] && (e - acc_e[k] < pulse_of(k))) return 8'd1 << acc_c[k];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    bit rb;
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      rb = m_ready(k, edge_n - 1);
      err_x[k] = 1'b0;
      if (rst) begin
        acc_v[k] = 1'b0;
        known    = 1'b1;
      end else if (valid && rb) begin
`ifdef DECODER3X8_PARITY_EN
        if (parity != ^code) begin
          err_x[k] = 1'b1;
        end else begin
          acc_v[k] = 1'b1; acc_e[k] = edge_n; acc_c[k] = code; accepts[k]++;
        end
`else
        acc_v[k] = 1'b1; acc_e[k] = edge_n; acc_c[k] = code; accepts[k]++;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (known) begin
      check("a.data",  a_if.data,  m_data(0, edge_n));
      check("a.ready", {7'd0, a_if.ready}, {7'd0, m_ready(0, edge_n)});
      check("a.busy",  {7'd0, a_if.busy},  {7'd0, !m_ready(0, edge_n)});
      check("b.data",  b_if.data,  m_data(1, edge_n));
      check("b.ready", {7'd0, b_if.ready}, {7'd0, m_ready(1, edge_n)});
      check("b.busy",  {7'd0, b_if.busy},  {7'd0, !m_ready(1, edge_n)});
`ifdef DECODER3X8_PARITY_EN
      check("a.err", {7'd0, a_if.err}, {7'd0, err_x[0]});
      check("b.err", {7'd0, b_if.err}, {7'd0, err_x[1]});
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    logic [7:0] exp_oh;

    // Reset then idle.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    check("idle_data",  a_if.data, 8'h00);
    check("idle_ready", {7'd0, a_if.ready}, 8'h01);
    check("idle_busy",  {7'd0, a_if.busy},  8'h00);

    // All codes back to back on instance a (4 cycles on, 2 cycles zero).
    a0 = accepts[0];
    valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      code   = 3'(i);
      parity = ^code;
      exp_oh = 8'd1 << i;
      step(1);
      check("allcodes_first", a_if.data, exp_oh);
      if (i == 5) check("allcodes_code5", a_if.data, 8'h20);
      if (i == 7) check("allcodes_code7", a_if.data, 8'h80);
      step(3);
      check("allcodes_last", a_if.data, exp_oh);
      step(1);
      check("allcodes_zero1", a_if.data, 8'h00);
      check("allcodes_busy",  {7'd0, a_if.ready}, 8'h00);
      step(1);
      check("allcodes_zero2", a_if.data, 8'h00);
      check("allcodes_ready", {7'd0, a_if.ready}, 8'h01);
    end
    valid = 1'b0;
    check("allcodes_count", 8'(accepts[0] - a0), 8'd8);

    // No gap on instance b: 08, 00, 20.
    step(6);
    code = 3'd3; parity = 1'b0; valid = 1'b1;
    step(1);
    check("nogap_08", b_if.data, 8'h08);
    code = 3'd5; parity = 1'b0;
    step(1);
    check("nogap_00", b_if.data, 8'h00);
    check("nogap_ready", {7'd0, b_if.ready}, 8'h01);
    step(1);
    check("nogap_20", b_if.data, 8'h20);
    valid = 1'b0;

    // Held input: code changes mid-pulse, data must not.
    step(6);
    code = 3'd2; parity = 1'b1; valid = 1'b1;
    step(1);
    check("held_04", a_if.data, 8'h04);
    code = 3'd6; parity = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step(1);
      check("held_stay", a_if.data, 8'h04);
    end
    step(1);
    check("held_zero", a_if.data, 8'h00);
    step(1);
    check("held_ready", {7'd0, a_if.ready}, 8'h01);
    step(1);
    check("held_40", a_if.data, 8'h40);
    valid = 1'b0;

    // Reset on the second DRIVE cycle of code 7.
    step(6);
    code = 3'd7; parity = 1'b1; valid = 1'b1;
    step(1);
    valid = 1'b0;
    check("rst_drive1", a_if.data, 8'h80);
    step(1);
    check("rst_drive2", a_if.data, 8'h80);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_data",  a_if.data, 8'h00);
    check("rst_ready", {7'd0, a_if.ready}, 8'h01);
    for (int j = 0; j < 5; j++) begin
      step(1);
      check("rst_no_residual", a_if.data, 8'h00);
    end

`ifdef DECODER3X8_PARITY_EN
    step(3);
    code = 3'd3; parity = 1'b1; valid = 1'b1;
    step(1);
    valid = 1'b0;
    check("par_err",   {7'd0, a_if.err},   8'h01);
    check("par_data",  a_if.data,          8'h00);
    check("par_ready", {7'd0, a_if.ready}, 8'h01);
    step(1);
    check("par_err_clear", {7'd0, a_if.err}, 8'h00);
    code = 3'd3; parity = 1'b0; valid = 1'b1;
    step(1);
    valid = 1'b0;
    check("par_ok_data", a_if.data, 8'h08);
    check("par_ok_err",  {7'd0, a_if.err}, 8'h00);
    step(6);
`endif

    // Randomized traffic, mostly-correct parity, occasional reset.
    for (int n = 0; n < 600; n++) begin
      valid  = ($urandom_range(0, 3) != 0);
      code   = 3'($urandom);
      parity = (^code) ^ ($urandom_range(0, 7) == 0);
      rst    = ($urandom_range(0, 63) == 0);
      step(1);
    end
    rst   = 1'b0;
    valid = 1'b0;
    step(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder3x8_pulse.md
# decoder3x8_pulse

Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a timed output pulse. It is the inverse of the 8-to-3 encoder: a 3-bit code is accepted and reproduced as an 8-bit one-hot word on `data`. That word is held for a fixed number of cycles, followed by a fixed quiet gap. It sits at the far end of an encoded select/strobe path and regenerates the one-hot lines the encoder consumed.

## Interface
- `PULSE_CYCLES`, default 4: cycles the one-hot word is driven; legal range 1..2^CNT_W-1.
- `GAP_CYCLES`, default 1: cycles of all-zero `data` after each pulse before the next code is accepted; legal range 0..2^CNT_W-1.
- `CNT_W`, default 8: width of the internal pulse/gap counter.
- `clk`, input, 1: single clock; all logic updates on the rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `code`, input, 3: binary index of the line to assert.
- `valid`, input, 1: `code` is presented.
- `ready`, output, 1: block can accept a code this cycle.
- `data`, output, 8: one-hot output, registered; `data[code]` is high during the pulse.
- `busy`, output, 1: high while in DRIVE or GAP.
- `parity`, input, 1: present only with `DECODER3X8_PARITY_EN`; even parity bit for `code`.
- `err`, output, 1: present only with `DECODER3X8_PARITY_EN`; one-cycle parity-error flag.

## Operation
- States:
  - IDLE: `ready`=1, `data`=0, `busy`=0.
  - DRIVE: `ready`=0, `data`=onehot, `busy`=1.
  - GAP: `ready`=0, `data`=0, `busy`=1.
- Reset (any state, any cycle): the next edge forces IDLE, `data`=8'h00, `ready`=1, `busy`=0, `err`=0, and counter=0.
- A handshake occurs on an edge where `valid`=1 and `ready`=1.
- IDLE→DRIVE on handshake: `data` ← `8'b1 << code` and counter ← PULSE_CYCLES-1.
- In DRIVE the counter decrements each cycle. At counter=0:
  - with GAP_CYCLES>0, go to GAP with counter ← GAP_CYCLES-1 and `data` ← 0;
  - with GAP_CYCLES=0, go straight to IDLE with `data` ← 0.
- In GAP the counter decrements each cycle; at counter=0 go to IDLE.
- While `ready`=0, `valid` and `code` are ignored. The sender must hold `code` until the handshake; no code is queued or buffered.
- `data` is always either all-zero or exactly one-hot, and never changes mid-pulse.
- `ready` is derived from the registered state only, with no combinational path from `valid`.

## Timing
- Handshake at edge T gives:
  - `data` one-hot during cycles T+1 .. T+PULSE_CYCLES;
  - `data`=0 from T+PULSE_CYCLES+1;
  - `ready` high again at T+PULSE_CYCLES+GAP_CYCLES+1.
- Minimum spacing between accepted codes is PULSE_CYCLES+GAP_CYCLES+1 cycles. Consecutive pulses are therefore always separated by at least one all-zero cycle, even when GAP_CYCLES=0.
- `rst` asserted during DRIVE: `data` drops to 0 at the reset edge, and the pulse is not resumed after reset.
- `rst` and a handshake on the same edge: reset wins and the code is discarded.
- `busy` and `ready` are complementary in every cycle.

## Configuration
- `DECODER3X8_PARITY_EN` defined:
  - `parity` and `err` ports exist.
  - On a handshake, if `parity` != ^`code`, the code is dropped: state stays IDLE, `data` stays 0, `ready` stays 1.
  - `err`=1 for exactly the one cycle after that edge, then returns to 0.
  - On a good-parity handshake, `err` stays 0.
- `DECODER3X8_PARITY_EN` undefined:
  - `parity` and `err` ports are absent.
  - Every handshake is accepted; otherwise behaviour is identical.

## Test plan
- Reset, then idle 3 cycles: `data`=8'h00, `ready`=1, `busy`=0 throughout.
- All codes: with PULSE_CYCLES=4 and GAP_CYCLES=1, send `code`=0..7 back to back with `valid` held high.
  - Each code produces `data`=8'h01, 8'h02, … 8'h80 for exactly 4 cycles.
  - Each pulse is followed by 2 zero cycles, giving one accept every 6 cycles.
- No GAP: with GAP_CYCLES=0 and PULSE_CYCLES=1, send `code`=3 then 5.
  - `data`=8'h08 for 1 cycle, then 8'h00 for 1 cycle, then 8'h20 for 1 cycle.
- Held input: during DRIVE for `code`=2, change `code` to 6 while `valid`=1.
  - `data` stays 8'h04 for the whole pulse.
  - 6 is accepted only once `ready` returns.
- Reset mid-pulse: assert `rst` on the 2nd DRIVE cycle of `code`=7.
  - `data`=8'h00 and `ready`=1 on the next cycle.
  - No residual pulse after `rst` deasserts.
- Parity (macro defined):
  - `code`=3 with `parity`=1 gives `err`=1 for one cycle, `data` stays 8'h00, `ready` stays 1.
  - `code`=3 with `parity`=0 gives `data`=8'h08 and `err`=0.
